bank_burst_ctrl: RTL and testbench
==================================

// Module: bank_burst_ctrl
// PURPOSE
//   Command-side stage directly upstream of Bank. Accepts ACT/RD/WR/PRE commands, tracks the open
//   row slot, expands each RD/WR into a BL-beat column burst (sequential wrap within the BL-aligned
//   block), and drives Bank's rd_o_wr/row/column/dqin. Returns read beats from Bank's dqout with a
//   valid strobe. Row addresses arrive already mapped to a CHWIDTH slot index.
// PARAMETERS
//   DEVICE_WIDTH  4   data bits per beat; matches Bank
//   COLWIDTH      10  column address width; matches Bank
//   CHWIDTH       5   row-slot address width; matches Bank
//   BL            8   burst length in beats; power of 2, 2..2**COLWIDTH
// PORTS
//   clk            in   1             single clock; all logic rises on posedge
//   rst_n          in   1             asynchronous, active-low reset
//   cmd_valid      in   1             command present
//   cmd_ready      out  1             command accepted when cmd_valid & cmd_ready
//   cmd_op         in   2             00 ACT, 01 RD, 10 WR, 11 PRE
//   cmd_row        in   CHWIDTH       row slot (ACT only)
//   cmd_col        in   COLWIDTH      start column (RD/WR only)
//   cmd_err        out  1             1-cycle pulse: illegal command accepted and discarded
//   wr_valid       in   1             write beat data present on wr_data
//   wr_data        in   DEVICE_WIDTH  write beat data
//   wr_ready       out  1             high in WR_BURST; beat consumed when wr_valid & wr_ready
//   rd_valid       out  1             rd_data holds a read beat
//   rd_data        out  DEVICE_WIDTH  read beat (Bank dqout pass-through)
//   bank_rd_o_wr   out  1             to Bank; 0 read, 1 write
//   bank_dqin      out  DEVICE_WIDTH  to Bank write data
//   bank_dqout     in   DEVICE_WIDTH  from Bank read data, valid 1 cycle after its address
//   bank_row       out  CHWIDTH       to Bank row
//   bank_column    out  COLWIDTH      to Bank column
// BEHAVIOUR
//   Reset (async assert, sync-released use): state IDLE; cmd_ready=1; cmd_err=0; wr_ready=0;
//     rd_valid=0; bank_rd_o_wr=0; bank_dqin=0; bank_row=0; bank_column=0; beat counter 0.
//   States: IDLE, ACTIVE, RD_BURST, WR_BURST. cmd_ready=1 only in IDLE and ACTIVE.
//   IDLE:   ACT -> latch open_row=cmd_row, go ACTIVE. PRE -> no-op, stay. RD/WR -> cmd_err, stay.
//   ACTIVE: RD -> RD_BURST; WR -> WR_BURST; latch base=cmd_col, beat=0. PRE -> IDLE.
//           ACT -> cmd_err, open row unchanged.
//   Column of beat k: {base[COLWIDTH-1:log2 BL], (base[log2 BL-1:0]+k) mod BL}; wraps in block.
//   RD_BURST: one beat/cycle, no stall; bank_rd_o_wr=0, bank_column=beat column. rd_valid=1 and
//     rd_data=bank_dqout the cycle after each beat address; BL consecutive rd_valid cycles.
//     After beat BL-1 -> ACTIVE (1 bubble before next accept). Trailing rd_valid in ACTIVE is legal.
//   WR_BURST: wr_ready=1. Beat with wr_valid=1: bank_rd_o_wr=1, bank_dqin=wr_data, column=beat
//     column, beat++ (all combinational to Bank same cycle). wr_valid=0: bank_rd_o_wr=0, beat
//     holds (stall, unbounded). After beat BL-1 consumed -> ACTIVE.
//   bank_rd_o_wr is 1 only on a consumed write beat; never in other states.
//   Outside bursts: bank_row=open_row, bank_column=0, bank_rd_o_wr=0.
//   cmd_err accepted only in IDLE/ACTIVE; pulse is registered (cycle after accept).
//   Reset mid-burst: burst aborted immediately, no further Bank write, pending rd_valid dropped.
// CONFIGURATION
//   AUTO_PRECHARGE_EN defined: extra input cmd_ap (1 bit). RD/WR with cmd_ap=1 returns to IDLE
//     (row closed) after the last beat instead of ACTIVE; cmd_ap ignored for ACT/PRE.
//   Undefined: port cmd_ap absent; bursts always return to ACTIVE.
// TESTING
//   ACT row 3; WR col 0x005, 8 beats data 1..8, wr_valid always 1 -> Bank cols 5,6,7,0,1,2,3,4
//     of row 3 written 1..8; wr_ready low after 8 beats.
//   Then RD col 0x005 -> 8 consecutive rd_valid, rd_data 1..8; first rd_valid 2 cycles after accept.
//   WR with wr_valid low on beats 2 and 5 for 3 cycles each -> no bank_rd_o_wr in stall
//     cycles, 8 writes total, column sequence unchanged.
//   RD in IDLE and ACT in ACTIVE -> cmd_err one pulse each, state/open row unchanged.
//   rst_n low at beat 3 of WR -> outputs at reset values that cycle, state IDLE, cols 3+ unwritten.
//   AUTO_PRECHARGE_EN: RD with cmd_ap=1 -> IDLE after burst; following RD -> cmd_err.

Source files
------------

// File: rtl/bank_burst_ctrl_if.sv
// bank_burst_ctrl_if: command, write-beat and read-beat handshakes between a
// requester (master) and bank_burst_ctrl (slave).
// Define AUTO_PRECHARGE_EN to add the cmd_ap signal.
interface bank_burst_ctrl_if #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [CHWIDTH-1:0]      cmd_row;
    logic [COLWIDTH-1:0]     cmd_col;
    logic                    cmd_err;
`ifdef AUTO_PRECHARGE_EN
    logic                    cmd_ap;
`endif
    logic                    wr_valid;
    logic [DEVICE_WIDTH-1:0] wr_data;
    logic                    wr_ready;
    logic                    rd_valid;
    logic [DEVICE_WIDTH-1:0] rd_data;

    modport master (
`ifdef AUTO_PRECHARGE_EN
        output cmd_ap,
`endif
        output cmd_valid, cmd_op, cmd_row, cmd_col,
        input  cmd_ready, cmd_err,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data
    );

    modport slave (
`ifdef AUTO_PRECHARGE_EN
        input  cmd_ap,
`endif
        input  cmd_valid, cmd_op, cmd_row, cmd_col,
        output cmd_ready, cmd_err,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/bank_burst_ctrl.sv
// bank_burst_ctrl: command stage in front of a Bank array. Tracks the open row
// slot and expands each RD/WR into a BL-beat column burst that wraps inside
// the BL-aligned column block. Read beats come back one cycle after their
// address as Bank dqout with rd_valid.
// Optional feature: define AUTO_PRECHARGE_EN to add cmd_ap; a RD/WR issued
// with cmd_ap=1 closes the row (returns to IDLE) after its last beat.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no open row; ACT opens one, PRE is a no-op, RD/WR illegal
// ACTIVE   | row open; RD/WR start a burst, PRE closes, ACT illegal
// RD_BURST | one read beat address per cycle, never stalls
// WR_BURST | one write beat per cycle in which wr_valid is high
module bank_burst_ctrl #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int BL           = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bank_burst_ctrl_if.slave        bus,
    output logic                    bank_rd_o_wr,
    output logic [DEVICE_WIDTH-1:0] bank_dqin,
    input  logic [DEVICE_WIDTH-1:0] bank_dqout,
    output logic [CHWIDTH-1:0]      bank_row,
    output logic [COLWIDTH-1:0]     bank_column
);
    localparam int                  BW        = (BL > 1) ? $clog2(BL) : 1;
    localparam logic [COLWIDTH-1:0] BLK_MASK  = COLWIDTH'(BL - 1);
    localparam logic [BW-1:0]       LAST_BEAT = BW'(BL - 1);

    localparam logic [1:0] OP_ACT = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_PRE = 2'b11;

    typedef enum logic [1:0] {IDLE, ACTIVE, RD_BURST, WR_BURST} state_t;

    state_t              state;
    logic [CHWIDTH-1:0]  open_row;
    logic [COLWIDTH-1:0] base;
    logic [BW-1:0]       beat;
    logic                close_after;
    logic                err_q;
    logic                rd_valid_q;

    logic                ap_req;
    logic                cmd_fire;
    logic                wr_fire;
    logic                last_beat;
    logic                in_burst;
    logic [COLWIDTH-1:0] beat_col;

`ifdef AUTO_PRECHARGE_EN
    assign ap_req = bus.cmd_ap;
`else
    assign ap_req = 1'b0;
`endif

    assign bus.cmd_ready = (state == IDLE) || (state == ACTIVE);
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign wr_fire       = (state == WR_BURST) && bus.wr_valid;
    assign last_beat     = (beat == LAST_BEAT);
    assign in_burst      = (state == RD_BURST) || (state == WR_BURST);

    // Upper column bits come from the start column; the low log2(BL) bits
    // count modulo BL so the burst wraps inside its aligned block.
    assign beat_col = (base & ~BLK_MASK) | ((base + COLWIDTH'(beat)) & BLK_MASK);

    // Bank-side signals are combinational so a consumed write beat reaches
    // Bank in the same cycle; reset forces them to idle values immediately.
    assign bank_row      = open_row;
    assign bank_column   = in_burst ? beat_col : '0;
    assign bank_rd_o_wr  = wr_fire;
    assign bank_dqin     = wr_fire ? bus.wr_data : '0;

    assign bus.wr_ready  = (state == WR_BURST);
    assign bus.cmd_err   = err_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = bank_dqout;

    // Command decode, burst sequencing and the registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            open_row    <= '0;
            base        <= '0;
            beat        <= '0;
            close_after <= 1'b0;
            err_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            rd_valid_q <= (state == RD_BURST);
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        case (bus.cmd_op)
                            OP_ACT: begin
                                open_row <= bus.cmd_row;
                                state    <= ACTIVE;
                            end
                            OP_PRE:  begin end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                ACTIVE: begin
                    if (cmd_fire) begin
                        case (bus.cmd_op)
                            OP_RD: begin
                                base        <= bus.cmd_col;
                                beat        <= '0;
                                close_after <= ap_req;
                                state       <= RD_BURST;
                            end
                            OP_WR: begin
                                base        <= bus.cmd_col;
                                beat        <= '0;
                                close_after <= ap_req;
                                state       <= WR_BURST;
                            end
                            OP_PRE:  state <= IDLE;
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                RD_BURST: begin
                    beat <= beat + 1'b1;
                    if (last_beat) begin
                        state <= close_after ? IDLE : ACTIVE;
                    end
                end
                WR_BURST: begin
                    if (bus.wr_valid) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            state <= close_after ? IDLE : ACTIVE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bank_burst_ctrl.sv
// tb_bank_burst_ctrl: drives bank_burst_ctrl against a behavioural Bank array
// and checks burst columns, write data, read data/timing, errors and reset.
module tb_bank_burst_ctrl;
    localparam int DW   = 4;
    localparam int COLW = 10;
    localparam int CHW  = 5;
    localparam int BL   = 8;

    localparam logic [1:0] OP_ACT = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_PRE = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bank_burst_ctrl_if #(.DEVICE_WIDTH(DW), .COLWIDTH(COLW), .CHWIDTH(CHW)) bus ();

    logic            bank_rd_o_wr;
    logic [DW-1:0]   bank_dqin;
    logic [DW-1:0]   bank_dqout;
    logic [CHW-1:0]  bank_row;
    logic [COLW-1:0] bank_column;

    bank_burst_ctrl #(.DEVICE_WIDTH(DW), .COLWIDTH(COLW), .CHWIDTH(CHW), .BL(BL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .bank_rd_o_wr (bank_rd_o_wr),
        .bank_dqin    (bank_dqin),
        .bank_dqout   (bank_dqout),
        .bank_row     (bank_row),
        .bank_column  (bank_column)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int err_cnt = 0;

    logic [DW-1:0] bank_mem [2**CHW][2**COLW];
    logic [DW-1:0] exp_mem  [2**CHW][2**COLW];

    typedef struct {
        int              cyc;
        logic [CHW-1:0]  row;
        logic [COLW-1:0] col;
        logic [DW-1:0]   data;
    } beat_t;

    beat_t wr_log[$];
    beat_t rd_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Bank: read data appears one cycle after its address; writes land at the edge.
    always @(posedge clk) begin
        bank_dqout <= bank_mem[bank_row][bank_column];
        if (bank_rd_o_wr === 1'b1) bank_mem[bank_row][bank_column] = bank_dqin;
    end

    // Passive monitor of Bank writes, returned read beats and error pulses.
    always @(negedge clk) begin
        beat_t b;
        b.cyc  = cyc;
        b.row  = bank_row;
        b.col  = bank_column;
        b.data = bank_dqin;
        if (bank_rd_o_wr === 1'b1) wr_log.push_back(b);
        if (bus.rd_valid === 1'b1) begin
            b.data = bus.rd_data;
            rd_log.push_back(b);
        end
        if (bus.cmd_err === 1'b1) err_cnt++;
    end

    // Column of beat k: aligned block of the start column, offset modulo BL.
    function automatic logic [COLW-1:0] beat_col(input logic [COLW-1:0] base, input int k);
        int blk;
        int off;
        blk = (int'(base) / BL) * BL;
        off = (int'(base) % BL + k) % BL;
        return COLW'(blk + off);
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [CHW-1:0] row,
                          input logic [COLW-1:0] col, output int acc);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_row   = row;
        bus.cmd_col   = col;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n >= 50) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b after 50 cycles, required 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [CHW-1:0] row, input logic [COLW-1:0] base,
                               input logic [DW-1:0] data [BL], input int stall [BL]);
        int acc;
        int k;
        int guard;
        k = 0;
        guard = 0;
        wr_log.delete();
        do_cmd(OP_WR, '0, base, acc);
        while (k < BL && guard < 200) begin
            vectors++;
            if (bus.wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL wr_ready_in_burst: got %b, required 1 (beat %0d)", bus.wr_ready, k);
            end
            if (stall[k] > 0) begin
                stall[k]--;
                bus.wr_valid = 1'b0;
                #1;
                vectors++;
                if (bank_rd_o_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_write: bank_rd_o_wr=%b, required 0 (beat %0d)", bank_rd_o_wr, k);
                end
            end else begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = data[k];
                exp_mem[row][beat_col(base, k)] = data[k];
                #1;
                vectors++;
                if (bank_rd_o_wr !== 1'b1 || bank_column !== beat_col(base, k)) begin
                    errors++;
                    $display("FAIL beat_drive: rd_o_wr=%b col=%0h, required 1 col=%0h",
                             bank_rd_o_wr, bank_column, beat_col(base, k));
                end
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.wr_valid = 1'b0;
        vectors++;
        if (bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_after: got %b, required 0", bus.wr_ready);
        end
        vectors++;
        if (wr_log.size() != BL) begin
            errors++;
            $display("FAIL write_count: got %0d writes, required %0d", wr_log.size(), BL);
        end
        for (int i = 0; i < BL && i < wr_log.size(); i++) begin
            vectors++;
            if (wr_log[i].row !== row || wr_log[i].col !== beat_col(base, i) || wr_log[i].data !== data[i]) begin
                errors++;
                $display("FAIL write_beat%0d: row=%0d col=%0h data=%0h, required row=%0d col=%0h data=%0h",
                         i, wr_log[i].row, wr_log[i].col, wr_log[i].data, row, beat_col(base, i), data[i]);
            end
        end
    endtask

    task automatic read_burst(input logic [CHW-1:0] row, input logic [COLW-1:0] base);
        int acc;
        rd_log.delete();
        do_cmd(OP_RD, '0, base, acc);
        repeat (BL + 3) @(posedge clk);
        #1;
        vectors++;
        if (rd_log.size() != BL) begin
            errors++;
            $display("FAIL read_count: got %0d rd_valid beats, required %0d", rd_log.size(), BL);
        end
        for (int i = 0; i < BL && i < rd_log.size(); i++) begin
            vectors++;
            if (rd_log[i].cyc != acc + 1 + i || rd_log[i].data !== exp_mem[row][beat_col(base, i)]) begin
                errors++;
                $display("FAIL read_beat%0d: cycle=%0d data=%0h, required cycle=%0d data=%0h",
                         i, rd_log[i].cyc, rd_log[i].data, acc + 1 + i, exp_mem[row][beat_col(base, i)]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.cmd_err !== 1'b0 || bus.wr_ready !== 1'b0 ||
            bus.rd_valid !== 1'b0 || bank_rd_o_wr !== 1'b0 || bank_dqin !== '0 ||
            bank_row !== '0 || bank_column !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b err=%b wrdy=%b rv=%b rw=%b dq=%0h row=%0d col=%0h, required 1 0 0 0 0 0 0 0",
                     bus.cmd_ready, bus.cmd_err, bus.wr_ready, bus.rd_valid, bank_rd_o_wr,
                     bank_dqin, bank_row, bank_column);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [DW-1:0] d [BL];
        int            s [BL];
        int            acc;
        for (int i = 0; i < BL; i++) begin
            d[i] = DW'(i + 1);
            s[i] = 0;
        end
        do_cmd(OP_ACT, 5'd3, '0, acc);
        vectors++;
        if (bank_row !== 5'd3) begin
            errors++;
            $display("FAIL open_row: got %0d, required 3", bank_row);
        end
        write_burst(5'd3, 10'h005, d, s);
        read_burst(5'd3, 10'h005);
    endtask

    task automatic test_wr_stall();
        logic [DW-1:0] d [BL];
        int            s [BL];
        for (int i = 0; i < BL; i++) begin
            d[i] = DW'($urandom_range(0, 15));
            s[i] = 0;
        end
        s[2] = 3;
        s[5] = 3;
        write_burst(5'd3, 10'h00B, d, s);
        read_burst(5'd3, 10'h00B);
    endtask

    task automatic test_errors();
        int acc;
        int e0;
        e0 = err_cnt;
        do_cmd(OP_ACT, 5'd9, '0, acc);
        vectors++;
        if (bus.cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL act_in_active_err: got %b, required 1", bus.cmd_err);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.cmd_err !== 1'b0 || bank_row !== 5'd3 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL act_in_active_after: err=%b row=%0d rdy=%b, required 0 3 1",
                     bus.cmd_err, bank_row, bus.cmd_ready);
        end
        do_cmd(OP_PRE, '0, '0, acc);
        vectors++;
        if (bus.cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL pre_no_err: got %b, required 0", bus.cmd_err);
        end
        do_cmd(OP_RD, '0, 10'h123, acc);
        vectors++;
        if (bus.cmd_err !== 1'b1 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_in_idle_err: err=%b wrdy=%b, required 1 0", bus.cmd_err, bus.wr_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.cmd_err !== 1'b0 || bus.rd_valid !== 1'b0 || bank_column !== '0) begin
            errors++;
            $display("FAIL rd_in_idle_after: err=%b rv=%b col=%0h, required 0 0 0",
                     bus.cmd_err, bus.rd_valid, bank_column);
        end
        do_cmd(OP_WR, '0, 10'h040, acc);
        vectors++;
        if (bus.cmd_err !== 1'b1 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_in_idle_err: err=%b wrdy=%b, required 1 0", bus.cmd_err, bus.wr_ready);
        end
        do_cmd(OP_ACT, 5'd9, '0, acc);
        @(posedge clk); #1;
        vectors++;
        if (err_cnt - e0 != 3 || bank_row !== 5'd9) begin
            errors++;
            $display("FAIL err_pulses: %0d pulse cycles, row=%0d, required 3 and row 9", err_cnt - e0, bank_row);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0]   d [BL];
        int              s [BL];
        logic [CHW-1:0]  row;
        logic [COLW-1:0] base;
        int              acc;
        int              e0;
        e0 = err_cnt;
        for (int it = 0; it < 10; it++) begin
            row  = CHW'($urandom_range(0, 2**CHW - 1));
            base = COLW'($urandom_range(0, 2**COLW - 1));
            for (int i = 0; i < BL; i++) begin
                d[i] = DW'($urandom_range(0, 15));
                s[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            do_cmd(OP_PRE, '0, '0, acc);
            do_cmd(OP_ACT, row, '0, acc);
            write_burst(row, base, d, s);
            read_burst(row, base);
            read_burst(row, COLW'($urandom_range(0, 2**COLW - 1)));
        end
        vectors++;
        if (err_cnt != e0) begin
            errors++;
            $display("FAIL random_no_err: %0d error pulses, required 0", err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [COLW-1:0] base;
        int              acc;
        base = 10'h010;
        do_cmd(OP_PRE, '0, '0, acc);
        do_cmd(OP_ACT, 5'd7, '0, acc);
        wr_log.delete();
        do_cmd(OP_WR, '0, base, acc);
        for (int k = 0; k < 3; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = DW'(k + 10);
            exp_mem[7][beat_col(base, k)] = DW'(k + 10);
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 4'hD;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.cmd_err !== 1'b0 || bus.wr_ready !== 1'b0 ||
            bus.rd_valid !== 1'b0 || bank_rd_o_wr !== 1'b0 || bank_dqin !== '0 ||
            bank_row !== '0 || bank_column !== '0) begin
            errors++;
            $display("FAIL mid_burst_reset: rdy=%b err=%b wrdy=%b rv=%b rw=%b dq=%0h row=%0d col=%0h, required 1 0 0 0 0 0 0 0",
                     bus.cmd_ready, bus.cmd_err, bus.wr_ready, bus.rd_valid, bank_rd_o_wr,
                     bank_dqin, bank_row, bank_column);
        end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (wr_log.size() != 3) begin
            errors++;
            $display("FAIL mid_burst_writes: got %0d writes, required 3", wr_log.size());
        end
        for (int k = 0; k < BL; k++) begin
            vectors++;
            if (bank_mem[7][beat_col(base, k)] !== exp_mem[7][beat_col(base, k)]) begin
                errors++;
                $display("FAIL mid_burst_col%0h: got %0h, required %0h", beat_col(base, k),
                         bank_mem[7][beat_col(base, k)], exp_mem[7][beat_col(base, k)]);
            end
        end
        do_cmd(OP_RD, '0, base, acc);
        vectors++;
        if (bus.cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: cmd_err=%b, required 1", bus.cmd_err);
        end
    endtask

`ifdef AUTO_PRECHARGE_EN
    task automatic test_auto_precharge();
        logic [DW-1:0] d [BL];
        int            s [BL];
        int            acc;
        for (int i = 0; i < BL; i++) begin
            d[i] = DW'($urandom_range(0, 15));
            s[i] = 0;
        end
        do_cmd(OP_ACT, 5'd2, '0, acc);
        bus.cmd_ap = 1'b1;
        write_burst(5'd2, 10'h3FA, d, s);
        bus.cmd_ap = 1'b0;
        do_cmd(OP_WR, '0, 10'h000, acc);
        vectors++;
        if (bus.cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL ap_wr_closes: cmd_err=%b, required 1", bus.cmd_err);
        end
        do_cmd(OP_ACT, 5'd2, '0, acc);
        bus.cmd_ap = 1'b1;
        read_burst(5'd2, 10'h3FA);
        bus.cmd_ap = 1'b0;
        do_cmd(OP_RD, '0, 10'h3FA, acc);
        vectors++;
        if (bus.cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL ap_rd_closes: cmd_err=%b, required 1", bus.cmd_err);
        end
        do_cmd(OP_ACT, 5'd2, '0, acc);
        read_burst(5'd2, 10'h3FA);
        do_cmd(OP_RD, '0, 10'h3FA, acc);
        vectors++;
        if (bus.cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL no_ap_stays_open: cmd_err=%b, required 0", bus.cmd_err);
        end
        repeat (BL + 3) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        for (int r = 0; r < 2**CHW; r++) begin
            for (int c = 0; c < 2**COLW; c++) begin
                bank_mem[r][c] = '0;
                exp_mem[r][c]  = '0;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_row   = '0;
        bus.cmd_col   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
`ifdef AUTO_PRECHARGE_EN
        bus.cmd_ap    = 1'b0;
`endif
        test_reset();
        test_directed();
        test_wr_stall();
        test_errors();
        test_random();
        test_reset_mid_burst();
`ifdef AUTO_PRECHARGE_EN
        test_auto_precharge();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
